eth_mac_cfg_regs: RTL

Parametrised configuration/status register block for the Ethernet MAC core. Decodes the MAC register map (control, station address, speed/interface mode, stats control) behind a req/ack register bus. Holds NUM_STATS saturating statistics counters. Drives static configuration outputs to the TX/RX datapaths and PHY-interface adapters. It replaces the bare constant set with a checked, stateful register file.

---
 rtl/eth_mac_pkg.sv | 50 +++++
 rtl/eth_mac_stat_counter.sv | 25 ++
 rtl/eth_mac_cfg_regs.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/eth_mac_pkg.sv
// rtl/eth_mac_pkg.sv - Ethernet MAC register map, mode encodings and config FSM states
package eth_mac_pkg;

   localparam logic [4:0] CONFIG_CONTROL    = 5'h00;
   localparam logic [4:0] CONFIG_ADDR_HI    = 5'h01;
   localparam logic [4:0] CONFIG_ADDR_LO    = 5'h02;
   localparam logic [4:0] CONFIG_SPEED_MODE = 5'h03;
   localparam logic [4:0] CONFIG_STATS_CTRL = 5'h04;
   localparam logic [4:0] CONFIG_STATS_BASE = 5'h10;

   localparam int CTRL_MAC_EN  = 0;
   localparam int CTRL_TX_EN   = 1;
   localparam int CTRL_RX_EN   = 2;
   localparam int CTRL_PROMISC = 3;

   localparam int STATS_FREEZE    = 0;
   localparam int STATS_CLEAR_ALL = 1;

   typedef enum logic [1:0] {
      SPEED_10M   = 2'b00,
      SPEED_100M  = 2'b01,
      SPEED_1000M = 2'b10,
      SPEED_RSVD  = 2'b11
   } speed_t;

   typedef enum logic [1:0] {
      MODE_MII   = 2'b00,
      MODE_GMII  = 2'b01,
      MODE_RGMII = 2'b10,
      MODE_RMII  = 2'b11
   } if_mode_t;

   typedef enum logic {
      CFG_IDLE = 1'b0,
      CFG_ACK  = 1'b1
   } cfg_state_t;

   // GMII only carries gigabit; MII/RMII cannot carry it; RGMII handles all rates.
   function automatic logic mode_valid(input logic [1:0] spd, input logic [1:0] ifm);
      logic ok;
      ok = 1'b0;
      case (spd)
         SPEED_10M, SPEED_100M: ok = (ifm != MODE_GMII);
         SPEED_1000M:           ok = (ifm == MODE_GMII) || (ifm == MODE_RGMII);
         default:               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/eth_mac_stat_counter.sv
// rtl/eth_mac_stat_counter.sv - saturating statistics counter with clear, freeze and read-clear
module eth_mac_stat_counter #(
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clear,
   input  logic              rd_clr,
   input  logic              freeze,
   output logic [STAT_W-1:0] count
);

   // A read-clear keeps a coincident increment so no event is lost; freeze does not block it.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (rd_clr) begin
         count <= STAT_W'(inc);
      end else if (inc && !freeze && (count != '1)) begin
         count <= count + STAT_W'(1);
      end
   end

endmodule

// File: rtl/eth_mac_cfg_regs.sv
// rtl/eth_mac_cfg_regs.sv - MAC config/status register file; ETH_MAC_CFG_STATS_COR_EN enables clear-on-read counters
module eth_mac_cfg_regs
   import eth_mac_pkg::*;
#(
   parameter int          ADDR_W         = 5,
   parameter int          DATA_W         = 32,
   parameter int          NUM_STATS      = 4,
   parameter int          STAT_W         = 32,
   parameter logic [47:0] RESET_MAC_ADDR = 48'h02_00_00_00_00_01
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_req,
   input  logic                 cfg_we,
   input  logic [ADDR_W-1:0]    cfg_addr,
   input  logic [DATA_W-1:0]    cfg_wdata,
   output logic                 cfg_ack,
   output logic [DATA_W-1:0]    cfg_rdata,
   output logic                 cfg_err,
   input  logic [NUM_STATS-1:0] stat_inc,
   output logic                 mac_enable,
   output logic                 tx_enable,
   output logic                 rx_enable,
   output logic                 promisc,
   output logic [47:0]          mac_addr,
   output logic [1:0]           speed_mode,
   output logic [1:0]           if_mode,
   output logic                 cfg_changed
);

   cfg_state_t state_q, state_d;
   logic       accept;

   speed_t     speed_q;
   if_mode_t   if_mode_q;
   logic       freeze_q;

   logic [STAT_W-1:0]    cnt [NUM_STATS];
   logic [NUM_STATS-1:0] stat_sel;
   logic [NUM_STATS-1:0] rd_clr;
   logic                 stat_hit;

   logic              is_ctrl, is_hi, is_lo, is_sm, is_sc;
   logic              addr_ok, mode_bad, req_err, wr_ok, clr_all;
   logic [DATA_W-1:0] rd_val;

   logic [DATA_W-1:0] rdata_q;
   logic              err_q, changed_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= CFG_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CFG_IDLE: if (cfg_req) state_d = CFG_ACK;
         CFG_ACK:  state_d = CFG_IDLE;
         default:  state_d = CFG_IDLE;
      endcase
   end

   assign accept  = (state_q == CFG_IDLE) && cfg_req;
   assign cfg_ack = (state_q == CFG_ACK);

   always_comb begin
      is_ctrl  = (cfg_addr == ADDR_W'(CONFIG_CONTROL));
      is_hi    = (cfg_addr == ADDR_W'(CONFIG_ADDR_HI));
      is_lo    = (cfg_addr == ADDR_W'(CONFIG_ADDR_LO));
      is_sm    = (cfg_addr == ADDR_W'(CONFIG_SPEED_MODE));
      is_sc    = (cfg_addr == ADDR_W'(CONFIG_STATS_CTRL));
      stat_hit = 1'b0;
      stat_sel = '0;
      rd_val   = '0;
      if (is_ctrl) begin
         rd_val[CTRL_MAC_EN]  = mac_enable;
         rd_val[CTRL_TX_EN]   = tx_enable;
         rd_val[CTRL_RX_EN]   = rx_enable;
         rd_val[CTRL_PROMISC] = promisc;
      end
      if (is_hi) rd_val[15:0] = mac_addr[47:32];
      if (is_lo) rd_val[31:0] = mac_addr[31:0];
      if (is_sm) rd_val[3:0]  = {if_mode_q, speed_q};
      if (is_sc) rd_val[STATS_FREEZE] = freeze_q;
      for (int i = 0; i < NUM_STATS; i++) begin
         if (cfg_addr == ADDR_W'(CONFIG_STATS_BASE) + ADDR_W'(i)) begin
            stat_hit    = 1'b1;
            stat_sel[i] = 1'b1;
            rd_val[STAT_W-1:0] = cnt[i];
         end
      end
   end

   // Mode changes are only legal while the MAC is stopped, and only for coherent rate/interface pairs.
   assign mode_bad = !mode_valid(cfg_wdata[1:0], cfg_wdata[3:2]) || mac_enable;
   assign addr_ok  = is_ctrl || is_hi || is_lo || is_sm || is_sc || stat_hit;
   assign req_err  = !addr_ok || (cfg_we && stat_hit) || (cfg_we && is_sm && mode_bad);
   assign wr_ok    = accept && cfg_we && !req_err;
   assign clr_all  = wr_ok && is_sc && cfg_wdata[STATS_CLEAR_ALL];

   always_ff @(posedge clk) begin
      if (rst) begin
         mac_enable <= 1'b0;
         tx_enable  <= 1'b0;
         rx_enable  <= 1'b0;
         promisc    <= 1'b0;
         mac_addr   <= RESET_MAC_ADDR;
         speed_q    <= SPEED_1000M;
         if_mode_q  <= MODE_GMII;
         freeze_q   <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         changed_q  <= 1'b0;
      end else begin
         rdata_q   <= '0;
         err_q     <= 1'b0;
         changed_q <= 1'b0;
         if (accept) begin
            rdata_q   <= cfg_we ? '0 : rd_val;
            err_q     <= req_err;
            changed_q <= wr_ok && (is_ctrl || is_hi || is_lo || is_sm);
         end
         if (wr_ok) begin
            if (is_ctrl) begin
               mac_enable <= cfg_wdata[CTRL_MAC_EN];
               tx_enable  <= cfg_wdata[CTRL_TX_EN];
               rx_enable  <= cfg_wdata[CTRL_RX_EN];
               promisc    <= cfg_wdata[CTRL_PROMISC];
            end
            if (is_hi) mac_addr[47:32] <= cfg_wdata[15:0];
            if (is_lo) mac_addr[31:0]  <= cfg_wdata[31:0];
            if (is_sm) begin
               speed_q   <= speed_t'(cfg_wdata[1:0]);
               if_mode_q <= if_mode_t'(cfg_wdata[3:2]);
            end
            if (is_sc) freeze_q <= cfg_wdata[STATS_FREEZE];
         end
      end
   end

   assign cfg_rdata   = rdata_q;
   assign cfg_err     = err_q;
   assign cfg_changed = changed_q;
   assign speed_mode  = speed_q;
   assign if_mode     = if_mode_q;

`ifdef ETH_MAC_CFG_STATS_COR_EN
   assign rd_clr = (accept && !cfg_we) ? stat_sel : '0;
`else
   assign rd_clr = '0;
`endif

   for (genvar g = 0; g < NUM_STATS; g++) begin : g_stat
      eth_mac_stat_counter #(
         .STAT_W (STAT_W)
      ) u_cnt (
         .clk    (clk),
         .rst    (rst),
         .inc    (stat_inc[g]),
         .clear  (clr_all),
         .rd_clr (rd_clr[g]),
         .freeze (freeze_q),
         .count  (cnt[g])
      );
   end

endmodule
